deck_shuffler: RTL and testbench



---
 rtl/deck_pkg.sv | 15 +
 rtl/lfsr16.sv | 23 ++
 rtl/deck_shuffler.sv | 116 +++++++++++
 tb/tb_deck_shuffler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/deck_pkg.sv
// rtl/deck_pkg.sv - shared sizes, LFSR constants, FSM state type and seed zero-guard for the deck shuffler
package deck_pkg;
  localparam int N_CARDS_DEFAULT = 52;
  localparam int IDX_W_DEFAULT   = 6;
  localparam int LFSR_W          = 16;
  localparam logic [LFSR_W-1:0] LFSR_MASK    = 16'hB400;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic {IDLE, RUN} state_t;

  // An all-zero LFSR state would lock up, so zero seeds become 1.
  function automatic logic [LFSR_W-1:0] nonzero_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR with enable, synchronous load and zero-guarded seeds
module lfsr16
  import deck_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_value,
  output logic [LFSR_W-1:0] value
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= nonzero_seed(SEED);
    end else if (load) begin
      value <= nonzero_seed(load_value);
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_MASK : '0);
    end
  end
endmodule

// File: rtl/deck_shuffler.sv
// rtl/deck_shuffler.sv - Fisher-Yates deck shuffler publishing a full permutation atomically on done
// Optional LFSR reseed ports (seed_load, seed_in) are enabled by DECK_SHUFFLER_RESEED_EN.
module deck_shuffler
  import deck_pkg::*;
#(
  parameter int                N_CARDS = N_CARDS_DEFAULT,
  parameter int                IDX_W   = IDX_W_DEFAULT,
  parameter logic [LFSR_W-1:0] SEED    = SEED_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
`ifdef DECK_SHUFFLER_RESEED_EN
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed_in,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [N_CARDS*IDX_W-1:0] shuffled_cards
);
  localparam int CNT_W  = IDX_W + 1;
  localparam int PROD_W = 2 * LFSR_W;

  state_t            state, next_state;
  logic [IDX_W-1:0]  step_i;
  logic [IDX_W-1:0]  work    [N_CARDS];
  logic [IDX_W-1:0]  swapped [N_CARDS];
  logic [LFSR_W-1:0] rnd;
  logic [CNT_W-1:0]  span;
  logic [PROD_W-1:0] product;
  logic [IDX_W-1:0]  j;
  logic              load_i, do_step, finish;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_seed;

`ifdef DECK_SHUFFLER_RESEED_EN
  assign lfsr_load = seed_load;
  assign lfsr_seed = seed_in;
`else
  assign lfsr_load = 1'b0;
  assign lfsr_seed = '0;
`endif

  // Free-running so the moment start arrives also contributes entropy.
  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .en         (1'b1),
    .load       (lfsr_load),
    .load_value (lfsr_seed),
    .value      (rnd)
  );

  // j = floor(rnd * (i+1) / 2^16) always lands in 0..i.
  assign span    = {1'b0, step_i} + CNT_W'(1);
  assign product = PROD_W'(rnd) * PROD_W'(span);
  assign j       = IDX_W'(product >> LFSR_W);

  always_comb begin
    swapped         = work;
    swapped[step_i] = work[j];
    swapped[j]      = work[step_i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_i     = 1'b0;
    do_step    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          load_i     = 1'b1;
        end
      end
      RUN: begin
        do_step = 1'b1;
        if (step_i == IDX_W'(1)) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_i <= '0;
      done   <= 1'b0;
      for (int k = 0; k < N_CARDS; k++) begin
        work[k]                         <= IDX_W'(k);
        shuffled_cards[IDX_W*k +: IDX_W] <= IDX_W'(k);
      end
    end else begin
      done <= finish;
      if (load_i)       step_i <= IDX_W'(N_CARDS - 1);
      else if (do_step) step_i <= step_i - IDX_W'(1);
      if (do_step) work <= swapped;
      // The final step's post-swap array is the only thing ever published.
      if (finish) begin
        for (int k = 0; k < N_CARDS; k++) begin
          shuffled_cards[IDX_W*k +: IDX_W] <= swapped[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_deck_shuffler.sv
// tb/tb_deck_shuffler.sv - scoreboard bench for deck_shuffler against a Fisher-Yates/LFSR reference
`timescale 1ns/1ps
module tb_deck_shuffler;
  localparam int N    = 52;
  localparam int W    = 6;
  localparam int BITS = N * W;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int STAT_RUNS = 1000;
  typedef logic [BITS-1:0] deck_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  start = 1'b0;
  logic  busy, done;
  deck_t shuffled_cards;
`ifdef DECK_SHUFFLER_RESEED_EN
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
`endif

  deck_shuffler #(.N_CARDS(N), .IDX_W(W), .SEED(SEED)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
`ifdef DECK_SHUFFLER_RESEED_EN
    .seed_load      (seed_load),
    .seed_in        (seed_in),
`endif
    .busy           (busy),
    .done           (done),
    .shuffled_cards (shuffled_cards)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    passed = 0;
  int    done_count = 0;
  logic [15:0] m_lfsr;
  int    m_work [N];
  deck_t exp_q [$];
  int    cnt [N][N];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic deck_t ident();
    deck_t d;
    for (int k = 0; k < N; k++) d[W*k +: W] = W'(k);
    return d;
  endfunction

  function automatic bit is_perm(input deck_t d);
    bit seen [N];
    int v;
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    for (int k = 0; k < N; k++) begin
      v = int'(d[W*k +: W]);
      if (v >= N) return 1'b0;
      if (seen[v]) return 1'b0;
      seen[v] = 1'b1;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
`ifdef DECK_SHUFFLER_RESEED_EN
    else if (seed_load) m_lfsr <= (seed_in == 16'h0) ? 16'h0001 : seed_in;
`endif
    else m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic check(input string tag, input deck_t obs, input deck_t exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that accepted start; m_lfsr then holds the value used for i = N-1.
  task automatic predict();
    logic [15:0] s;
    logic [31:0] p;
    int jj, t;
    deck_t d;
    s = m_lfsr;
    for (int i = N - 1; i >= 1; i--) begin
      p  = 32'(s) * 32'(i + 1);
      jj = int'(p >> 16);
      t = m_work[i]; m_work[i] = m_work[jj]; m_work[jj] = t;
      s = lfsr_next(s);
    end
    for (int k = 0; k < N; k++) d[W*k +: W] = W'(m_work[k]);
    exp_q.push_back(d);
  endtask

  task automatic run_to_done(output int n, output bit stable);
    n = 0;
    stable = 1'b1;
    while (!done && n < 200) begin
      if (shuffled_cards !== ident()) stable = 1'b0;
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    exp_q.delete();
    for (int k = 0; k < N; k++) m_work[k] = k;
    rst = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    deck_t e;
    if (!rst && done) begin
      done_count++;
      check("done_expected", deck_t'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("perm_vs_model", shuffled_cards, e);
      end
      check("perm_valid", deck_t'(is_perm(shuffled_cards)), 1);
    end
  end

`ifdef DECK_SHUFFLER_RESEED_EN
  task automatic run_seeded(input logic [15:0] s, output deck_t r);
    int n;
    bit st;
    do_reset();
    seed_load = 1'b1;
    seed_in   = s;
    tick();
    seed_load = 1'b0;
    start = 1'b1;
    tick();
    predict();
    start = 1'b0;
    run_to_done(n, st);
    check("reseed_latency", n, 51);
    r = shuffled_cards;
    tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    int    n, dc0, spacing, empty;
    bit    stable;
    deck_t res_a;
    real   e, chi, diff;
`ifdef DECK_SHUFFLER_RESEED_EN
    deck_t r1, r2;
`endif
    for (int k = 0; k < N; k++) m_work[k] = k;
    for (int p = 0; p < N; p++) for (int v = 0; v < N; v++) cnt[p][v] = 0;

    // reset and idle
    repeat (3) tick();
    check("reset_cards", shuffled_cards, ident());
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    repeat (10) tick();
    check("idle_cards", shuffled_cards, ident());
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // basic shuffle
    start = 1'b1;
    tick();
    predict();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    run_to_done(n, stable);
    check("latency_basic", n, 51);
    check("identity_until_done", stable, 1);
    check("busy_in_done_cycle", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("basic_done_count", done_count, 1);

    // held start: ignored while busy, re-accepted in the done cycle
    start = 1'b1;
    tick();
    predict();
    dc0 = done_count;
    run_to_done(n, stable);
    check("latency_held", n, 51);
    res_a = shuffled_cards;
    tick();
    predict();
    start = 1'b0;
    check("held_start_one_done", done_count - dc0, 1);
    check("busy_retrigger", busy, 1);
    run_to_done(n, stable);
    check("latency_retrigger", n, 51);
    check("retrigger_differs", (shuffled_cards != res_a), 1);
    tick();

    // reset in the middle of a shuffle
    start = 1'b1;
    tick();
    predict();
    start = 1'b0;
    repeat (19) tick();
    check("busy_before_reset", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_reset_cards", shuffled_cards, ident());
    check("mid_reset_busy", busy, 0);
    exp_q.delete();
    for (int k = 0; k < N; k++) m_work[k] = k;
    dc0 = done_count;
    tick();
    tick();
    rst = 1'b0;
    repeat (60) tick();
    check("no_done_after_reset", done_count - dc0, 0);
    check("cards_after_reset", shuffled_cards, ident());

    // statistics with random start spacing
    for (int r = 0; r < STAT_RUNS; r++) begin
      spacing = $urandom_range(0, 3);
      repeat (spacing) tick();
      start = 1'b1;
      tick();
      predict();
      start = 1'b0;
      run_to_done(n, stable);
      if (n != 51) check("stat_latency", n, 51);
      for (int p = 0; p < N; p++) cnt[p][int'(shuffled_cards[W*p +: W]) % N]++;
    end
    tick();
    empty = 0;
    chi = 0.0;
    e = real'(STAT_RUNS) / real'(N);
    for (int p = 0; p < N; p++) begin
      for (int v = 0; v < N; v++) begin
        if (cnt[p][v] == 0) empty++;
        diff = real'(cnt[p][v]) - e;
        chi += diff * diff / e;
      end
    end
    check("all_values_all_positions", empty, 0);
    check("chi2_mean_within_99pct", (chi / real'(N) < 77.4), 1);
    check("stat_done_count", done_count, STAT_RUNS + 3);

`ifdef DECK_SHUFFLER_RESEED_EN
    run_seeded(16'h1234, r1);
    run_seeded(16'h1234, r2);
    check("reseed_repeatable", r2, r1);
    run_seeded(16'h0000, r1);
    run_seeded(16'h0001, r2);
    check("reseed_zero_is_one", r1, r2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
